calc_op_sequencer: RTL and testbench
====================================

Name: calc_op_sequencer

Overview:
- Keypad-driven sequencer between the key scanner (key/key_valid) and a multi-cycle calculator ALU.
- Accumulates decimal operands A and B and decodes operator keys, including double-press upgrades.
- Issues a start/done handshake to the ALU, latches the result and drives display value, operator code and status flags.
- Sits between key_controller and the shared ALU; display_control consumes its outputs.

Parameters:
- OPW, 4, operand width; digit entry saturates at 2^OPW-1.
- RW, 8, ALU result / display width.
- TIMEOUT_CYC, 1024, ALU watchdog limit in clk cycles (used only with the optional feature).

Ports:
- clk  input  1  system clock
- reset_n  input  1  asynchronous, active-low reset
- key  input  4  key code: 0-9 digit, 10 '+', 11 '-', 12 '/', 13 '*', 14 '=', 15 clear
- key_valid  input  1  one-cycle strobe qualifying key
- alu_start  output  1  one-cycle request pulse to the ALU
- alu_a  output  OPW  operand A, held stable from alu_start until alu_done
- alu_b  output  OPW  operand B, same stability rule as alu_a
- alu_op  output  3  000 add, 001 sub, 010 div, 011 mul, 100 pow, 101 pct
- alu_done  input  1  one-cycle completion strobe from the ALU
- alu_result  input  RW  ALU result, valid while alu_done=1
- disp_value  output  RW  value to display
- disp_op  output  4  operator key code to display, 0 = none
- busy  output  1  high while in ISSUE or WAIT
- err  output  1  sticky error flag, cleared by the clear key or reset

Behaviour:
- Reset (async assert, sync release): state=ENTER_A, A=B=0, alu_op=000, alu_start=0, busy=0, err=0, disp_value=0, disp_op=0. All outputs are registered.
- States: ENTER_A, ENTER_B, ISSUE, WAIT, SHOW, ERROR. Keys are acted on only in cycles with key_valid=1.
- ENTER_A:
  - Digit d: A <= min(A*10+d, 2^OPW-1); disp_value <= new A.
  - Operator key: set op, disp_op <= key, go to ENTER_B with B=0 and b_typed=0.
  - '=' ignored.
- ENTER_B:
  - Digit: B accumulates with the same saturation; b_typed <= 1; disp_value <= B.
  - Repeat press of the same operator while b_typed=0: '*' upgrades op to pow, '/' upgrades to pct. A third press reverts to the base op.
  - A different operator while b_typed=0 replaces op.
  - Any operator with b_typed=1 is ignored.
  - '=': go to ERROR if op is div or pct and B==0, otherwise go to ISSUE.
- ISSUE: alu_start=1 for exactly one cycle; alu_a/alu_b/alu_op registered from A/B/op. Next state is WAIT.
- Latency: '=' strobe at edge N -> alu_start high after edge N+1.
- WAIT:
  - On alu_done: disp_value <= alu_result on the same edge, go to SHOW.
  - Non-clear keys are dropped.
  - Clear is recorded as pending. On alu_done the result is discarded and the block goes to ENTER_A with everything zeroed.
  - alu_done outside WAIT is ignored.
- SHOW:
  - Operator key: A <= min(result, 2^OPW-1) (chaining), go to ENTER_B.
  - Digit: A <= d, disp_op <= 0, go to ENTER_A.
  - '=' ignored.
- ERROR: err=1, disp_value=all ones. Only the clear key leaves ERROR.
- Clear key in any state except WAIT: return to the reset state on the next edge.
- key_valid coincident with alu_done in WAIT: the done is processed and a non-clear key is dropped.
- Reset asserted mid-WAIT: the sequencer returns to ENTER_A. A late alu_done afterwards is ignored.

Optional Feature:
- Macro: CALC_SEQ_TIMEOUT_EN.
- Defined: a counter runs in WAIT. If TIMEOUT_CYC cycles elapse without alu_done, go to ERROR with err=1; a subsequent alu_done is ignored.
- Undefined: no counter is instantiated and WAIT waits indefinitely.

Test Plan:
- Keys 7,'+',5,'=', ALU returns 12 three cycles after start -> one alu_start with a=7, b=5, op=000; disp_value=12 one edge after alu_done; busy high only during ISSUE/WAIT.
- Keys 1,2,'*','*',2,'=' -> alu_op=100, a=12, b=2, disp_op=13.
- Keys 9,'/','=' (B=0) -> no alu_start; err=1, disp_value=8'hFF; key 15 -> err=0, disp_value=0.
- Keys 9,9,9 -> A saturates at 15; keys '-',3,'=' -> alu_a=15, alu_b=3.
- After the first scenario, keys '+',4,'=' -> alu_a=12 (chained), b=4. Clear pressed in WAIT -> on alu_done, state=ENTER_A and disp_value=0.
- With CALC_SEQ_TIMEOUT_EN and TIMEOUT_CYC=16, withhold alu_done -> err=1 after 16 WAIT cycles; a later alu_done leaves disp_value=8'hFF.

Source files
------------

// File: rtl/calc_op_sequencer.sv
// Keypad-to-ALU sequencer: decimal operand entry, operator decode, ALU handshake, display drive.
// Optional ALU watchdog enabled by defining CALC_SEQ_TIMEOUT_EN.
module calc_op_sequencer #(
  parameter int unsigned OPW         = 4,
  parameter int unsigned RW          = 8,
  parameter int unsigned TIMEOUT_CYC = 1024
) (
  input  logic           clk,
  input  logic           reset_n,
  input  logic [3:0]     key,
  input  logic           key_valid,
  output logic           alu_start,
  output logic [OPW-1:0] alu_a,
  output logic [OPW-1:0] alu_b,
  output logic [2:0]     alu_op,
  input  logic           alu_done,
  input  logic [RW-1:0]  alu_result,
  output logic [RW-1:0]  disp_value,
  output logic [3:0]     disp_op,
  output logic           busy,
  output logic           err
);

  localparam int unsigned AW = OPW + 4;
  localparam logic [OPW-1:0] OPMAX = '1;

  localparam logic [2:0] OP_ADD = 3'd0, OP_SUB = 3'd1, OP_DIV = 3'd2,
                         OP_MUL = 3'd3, OP_POW = 3'd4, OP_PCT = 3'd5;
  localparam logic [3:0] K_ADD = 4'd10, K_SUB = 4'd11, K_DIV = 4'd12,
                         K_MUL = 4'd13, K_EQ = 4'd14, K_CLR = 4'd15;

  typedef enum logic [2:0] {
    S_ENTER_A, S_ENTER_B, S_ISSUE, S_WAIT, S_SHOW, S_ERROR
  } state_t;

  state_t         state, state_d;
  logic [OPW-1:0] a, a_d, b, b_d;
  logic [2:0]     op, op_d;
  logic           b_typed, b_typed_d, clr_pend, clr_pend_d;
  logic           alu_start_d, busy_d, err_d;
  logic [OPW-1:0] alu_a_d, alu_b_d;
  logic [2:0]     alu_op_d;
  logic [RW-1:0]  disp_value_d;
  logic [3:0]     disp_op_d;
  logic           tmo_hit;

  // Shift in one decimal digit, saturating at the operand maximum.
  function automatic logic [OPW-1:0] digit_acc(input logic [OPW-1:0] v, input logic [3:0] d);
    logic [AW-1:0] t;
    t = AW'(v) * AW'(10) + AW'(d);
    return (t > AW'(OPMAX)) ? OPMAX : OPW'(t);
  endfunction

  function automatic logic [OPW-1:0] sat_res(input logic [RW-1:0] r);
    return (r > RW'(OPMAX)) ? OPMAX : OPW'(r);
  endfunction

  function automatic logic [2:0] base_op(input logic [3:0] k);
    case (k)
      K_SUB:   return OP_SUB;
      K_DIV:   return OP_DIV;
      K_MUL:   return OP_MUL;
      default: return OP_ADD;
    endcase
  endfunction

`ifdef CALC_SEQ_TIMEOUT_EN
  localparam int unsigned TW = $clog2(TIMEOUT_CYC + 1);
  logic [TW-1:0] tmo_cnt;

  // Counts cycles spent in WAIT; cleared whenever the FSM is elsewhere.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)            tmo_cnt <= '0;
    else if (state == S_WAIT) tmo_cnt <= tmo_cnt + 1'b1;
    else                     tmo_cnt <= '0;
  end

  assign tmo_hit = (state == S_WAIT) && (tmo_cnt == TW'(TIMEOUT_CYC - 1));
`else
  // Watchdog compiled out: WAIT never times out.
  assign tmo_hit = 1'b0 & (TIMEOUT_CYC == 0);
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= S_ENTER_A;
      a          <= '0;
      b          <= '0;
      op         <= OP_ADD;
      b_typed    <= 1'b0;
      clr_pend   <= 1'b0;
      alu_start  <= 1'b0;
      alu_a      <= '0;
      alu_b      <= '0;
      alu_op     <= OP_ADD;
      disp_value <= '0;
      disp_op    <= '0;
      busy       <= 1'b0;
      err        <= 1'b0;
    end else begin
      state      <= state_d;
      a          <= a_d;
      b          <= b_d;
      op         <= op_d;
      b_typed    <= b_typed_d;
      clr_pend   <= clr_pend_d;
      alu_start  <= alu_start_d;
      alu_a      <= alu_a_d;
      alu_b      <= alu_b_d;
      alu_op     <= alu_op_d;
      disp_value <= disp_value_d;
      disp_op    <= disp_op_d;
      busy       <= busy_d;
      err        <= err_d;
    end
  end

  always_comb begin
    logic is_digit, is_oper, do_clr, pend;
    state_d      = state;
    a_d          = a;
    b_d          = b;
    op_d         = op;
    b_typed_d    = b_typed;
    clr_pend_d   = clr_pend;
    alu_start_d  = 1'b0;
    alu_a_d      = alu_a;
    alu_b_d      = alu_b;
    alu_op_d     = alu_op;
    disp_value_d = disp_value;
    disp_op_d    = disp_op;
    err_d        = err;
    busy_d       = 1'b0;
    is_digit     = key < 4'd10;
    is_oper      = (key >= K_ADD) && (key <= K_MUL);
    do_clr       = key_valid && (key == K_CLR) && (state != S_WAIT);
    pend         = clr_pend || (key_valid && key == K_CLR);

    case (state)
      S_ENTER_A: begin
        if (key_valid && is_digit) begin
          a_d          = digit_acc(a, key);
          disp_value_d = RW'(a_d);
        end else if (key_valid && is_oper) begin
          op_d      = base_op(key);
          disp_op_d = key;
          b_d       = '0;
          b_typed_d = 1'b0;
          state_d   = S_ENTER_B;
        end
      end
      S_ENTER_B: begin
        if (key_valid && is_digit) begin
          b_d          = digit_acc(b, key);
          b_typed_d    = 1'b1;
          disp_value_d = RW'(b_d);
        end else if (key_valid && is_oper && !b_typed) begin
          // Repeat press toggles '*'<->pow and '/'<->pct; other keys replace the op.
          if (key == disp_op && key == K_MUL)      op_d = (op == OP_MUL) ? OP_POW : OP_MUL;
          else if (key == disp_op && key == K_DIV) op_d = (op == OP_DIV) ? OP_PCT : OP_DIV;
          else                                     op_d = base_op(key);
          disp_op_d = key;
        end else if (key_valid && key == K_EQ) begin
          if ((op == OP_DIV || op == OP_PCT) && b == '0) begin
            state_d      = S_ERROR;
            err_d        = 1'b1;
            disp_value_d = '1;
          end else begin
            state_d = S_ISSUE;
          end
        end
      end
      S_ISSUE: begin
        alu_start_d = 1'b1;
        alu_a_d     = a;
        alu_b_d     = b;
        alu_op_d    = op;
        state_d     = S_WAIT;
      end
      S_WAIT: begin
        clr_pend_d = pend;
        if (alu_done) begin
          if (pend) do_clr = 1'b1;
          else begin
            disp_value_d = alu_result;
            state_d      = S_SHOW;
          end
        end else if (tmo_hit) begin
          if (pend) do_clr = 1'b1;
          else begin
            state_d      = S_ERROR;
            err_d        = 1'b1;
            disp_value_d = '1;
          end
        end
      end
      S_SHOW: begin
        if (key_valid && is_oper) begin
          a_d       = sat_res(disp_value);
          op_d      = base_op(key);
          disp_op_d = key;
          b_d       = '0;
          b_typed_d = 1'b0;
          state_d   = S_ENTER_B;
        end else if (key_valid && is_digit) begin
          a_d          = OPW'(key);
          disp_value_d = RW'(key);
          disp_op_d    = '0;
          state_d      = S_ENTER_A;
        end
      end
      S_ERROR: begin
        err_d        = 1'b1;
        disp_value_d = '1;
      end
      default: state_d = S_ENTER_A;
    endcase

    // Clear returns every register to its reset value.
    if (do_clr) begin
      state_d      = S_ENTER_A;
      a_d          = '0;
      b_d          = '0;
      op_d         = OP_ADD;
      b_typed_d    = 1'b0;
      clr_pend_d   = 1'b0;
      alu_start_d  = 1'b0;
      alu_a_d      = '0;
      alu_b_d      = '0;
      alu_op_d     = OP_ADD;
      disp_value_d = '0;
      disp_op_d    = '0;
      err_d        = 1'b0;
    end

    busy_d = (state_d == S_ISSUE) || (state_d == S_WAIT);
  end

endmodule

// File: tb/tb_calc_op_sequencer.sv
// Directed self-checking bench for calc_op_sequencer with a hand-driven ALU.
module tb_calc_op_sequencer;

  logic       clk = 1'b0;
  logic       reset_n;
  logic [3:0] key;
  logic       key_valid;
  logic       alu_start;
  logic [3:0] alu_a, alu_b;
  logic [2:0] alu_op;
  logic       alu_done;
  logic [7:0] alu_result;
  logic [7:0] disp_value;
  logic [3:0] disp_op;
  logic       busy, err;

  int n_chk = 0;
  int n_err = 0;

  calc_op_sequencer #(.OPW(4), .RW(8), .TIMEOUT_CYC(16)) dut (
    .clk(clk), .reset_n(reset_n), .key(key), .key_valid(key_valid),
    .alu_start(alu_start), .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op),
    .alu_done(alu_done), .alu_result(alu_result),
    .disp_value(disp_value), .disp_op(disp_op), .busy(busy), .err(err)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic press(input logic [3:0] k);
    @(negedge clk);
    key       = k;
    key_valid = 1'b1;
    @(negedge clk);
    key_valid = 1'b0;
  endtask

  // Called right after '=' is accepted: ISSUE now, start pulse on the next cycle.
  task automatic expect_issue(input string tag, input int ea, input int eb, input int eop);
    check_eq({tag, " start_lat"}, 32'(alu_start), 32'd0);
    check_eq({tag, " busy_issue"}, 32'(busy), 32'd1);
    @(negedge clk);
    check_eq({tag, " start"}, 32'(alu_start), 32'd1);
    check_eq({tag, " a"}, 32'(alu_a), 32'(ea));
    check_eq({tag, " b"}, 32'(alu_b), 32'(eb));
    check_eq({tag, " op"}, 32'(alu_op), 32'(eop));
  endtask

  task automatic alu_reply(input string tag, input logic [7:0] res);
    repeat (2) @(negedge clk);
    check_eq({tag, " start_pulse"}, 32'(alu_start), 32'd0);
    check_eq({tag, " busy_wait"}, 32'(busy), 32'd1);
    alu_done   = 1'b1;
    alu_result = res;
    @(negedge clk);
    alu_done = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    reset_n = 1'b0; key = '0; key_valid = 1'b0; alu_done = 1'b0; alu_result = '0;
    repeat (3) @(negedge clk);
    check_eq("rst disp_value", 32'(disp_value), 32'd0);
    check_eq("rst disp_op", 32'(disp_op), 32'd0);
    check_eq("rst err", 32'(err), 32'd0);
    check_eq("rst busy", 32'(busy), 32'd0);
    check_eq("rst alu_op", 32'(alu_op), 32'd0);
    check_eq("rst alu_start", 32'(alu_start), 32'd0);
    reset_n = 1'b1;

    // 7 + 5 = 12
    press(4'd7);  check_eq("s1 disp7", 32'(disp_value), 32'd7);
    press(4'd10); check_eq("s1 disp_op", 32'(disp_op), 32'd10);
    press(4'd5);  check_eq("s1 disp5", 32'(disp_value), 32'd5);
    press(4'd14);
    expect_issue("s1", 7, 5, 0);
    alu_reply("s1", 8'd12);
    check_eq("s1 result", 32'(disp_value), 32'd12);
    check_eq("s1 busy_done", 32'(busy), 32'd0);

    // Chain from 12, then clear while waiting
    press(4'd10); press(4'd4); press(4'd14);
    expect_issue("s5", 12, 4, 0);
    press(4'd15);
    check_eq("s5 busy_pend", 32'(busy), 32'd1);
    alu_reply("s5", 8'd16);
    check_eq("s5 disp_cleared", 32'(disp_value), 32'd0);
    check_eq("s5 disp_op_cleared", 32'(disp_op), 32'd0);
    check_eq("s5 busy", 32'(busy), 32'd0);
    press(4'd3);  check_eq("s5 enter_a", 32'(disp_value), 32'd3);

    // Stray alu_done outside WAIT is ignored
    @(negedge clk); alu_done = 1'b1; alu_result = 8'd99;
    @(negedge clk); alu_done = 1'b0;
    check_eq("late_done", 32'(disp_value), 32'd3);

    // 12 ** 2 via double '*'
    press(4'd15); press(4'd1); press(4'd2);
    check_eq("s2 disp12", 32'(disp_value), 32'd12);
    press(4'd13); press(4'd13); press(4'd2);
    check_eq("s2 disp_op", 32'(disp_op), 32'd13);
    press(4'd14);
    expect_issue("s2", 12, 2, 4);
    alu_reply("s2", 8'd144);
    check_eq("s2 result", 32'(disp_value), 32'd144);
    // Chaining saturates 144 to 15
    press(4'd11); press(4'd3); press(4'd14);
    expect_issue("s2c", 15, 3, 1);
    alu_reply("s2c", 8'd12);
    // Digit in SHOW restarts A; triple '/' reverts to div
    press(4'd9);
    check_eq("show digit disp", 32'(disp_value), 32'd9);
    check_eq("show digit disp_op", 32'(disp_op), 32'd0);
    press(4'd12); press(4'd12); press(4'd12); press(4'd3); press(4'd14);
    expect_issue("tri", 9, 3, 2);
    alu_reply("tri", 8'd3);

    // Divide by zero
    press(4'd15); press(4'd9); press(4'd12); press(4'd14);
    check_eq("s3 err", 32'(err), 32'd1);
    check_eq("s3 disp_ff", 32'(disp_value), 32'd255);
    check_eq("s3 busy", 32'(busy), 32'd0);
    @(negedge clk);
    check_eq("s3 no_start", 32'(alu_start), 32'd0);
    press(4'd5);  check_eq("s3 sticky", 32'(disp_value), 32'd255);
    press(4'd15);
    check_eq("s3 err_clr", 32'(err), 32'd0);
    check_eq("s3 disp_clr", 32'(disp_value), 32'd0);

    // Saturation; operator after typed B ignored; key coincident with done dropped
    press(4'd9); press(4'd9); press(4'd9);
    check_eq("s4 sat", 32'(disp_value), 32'd15);
    press(4'd11); press(4'd3); press(4'd10);
    check_eq("s4 op_kept", 32'(disp_op), 32'd11);
    press(4'd14);
    expect_issue("s4", 15, 3, 1);
    repeat (2) @(negedge clk);
    key = 4'd2; key_valid = 1'b1; alu_done = 1'b1; alu_result = 8'd12;
    @(negedge clk);
    key_valid = 1'b0; alu_done = 1'b0;
    check_eq("coinc result", 32'(disp_value), 32'd12);
    check_eq("coinc disp_op", 32'(disp_op), 32'd11);
    press(4'd10); press(4'd14);
    expect_issue("coinc chain", 12, 0, 0);
    alu_reply("coinc chain", 8'd12);

    // Reset during WAIT, then a late done
    press(4'd15); press(4'd2); press(4'd10); press(4'd3); press(4'd14);
    expect_issue("rw", 2, 3, 0);
    @(negedge clk); reset_n = 1'b0;
    @(negedge clk); reset_n = 1'b1;
    check_eq("rw busy", 32'(busy), 32'd0);
    alu_done = 1'b1; alu_result = 8'd5;
    @(negedge clk); alu_done = 1'b0;
    check_eq("rw late_done", 32'(disp_value), 32'd0);
    check_eq("rw busy2", 32'(busy), 32'd0);

`ifdef CALC_SEQ_TIMEOUT_EN
    begin
      int cyc;
      press(4'd15); press(4'd1); press(4'd10); press(4'd1); press(4'd14);
      cyc = 0;
      while (!err && cyc < 40) begin
        @(negedge clk);
        cyc++;
      end
      check_eq("tmo err", 32'(err), 32'd1);
      check_eq("tmo cycles", 32'(cyc), 32'd17);
      alu_done = 1'b1; alu_result = 8'd2;
      @(negedge clk); alu_done = 1'b0;
      check_eq("tmo disp_ff", 32'(disp_value), 32'd255);
    end
`endif

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
